fifo_ptr_ctrl: RTL
==================

FIFO_PTR_CTRL -- requirements
Module: fifo_ptr_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, memory address width; depth DEPTH = 2**ADDR_WIDTH.
REQ-002 SHALL have parameter AF_LEVEL, default DEPTH-4, almost_full threshold (entries).
REQ-003 SHALL have parameter AE_LEVEL, default 4, almost_empty threshold (entries).
REQ-004 SHALL have clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have write_ena  input  1  write request.
REQ-007 SHALL have read_ena  input  1  read request.
REQ-008 SHALL have flush  input  1  synchronous clear of pointers and count.
REQ-009 SHALL have clear_err  input  1  synchronous clear of sticky error flags.
REQ-010 SHALL have write_addr  output  ADDR_WIDTH  memory write address (low bits of write pointer).
REQ-011 SHALL have read_addr  output  ADDR_WIDTH  memory read address (low bits of read pointer).
REQ-012 SHALL have write_accept / read_accept  output  1 each  combinational qualified strobes to the memory.
REQ-013 SHALL have full, empty, almost_full, almost_empty  output  1 each  registered status flags.
REQ-014 SHALL have count  output  ADDR_WIDTH+1  registered occupancy, 0..DEPTH.
REQ-015 SHALL have overflow, underflow  output  1 each  sticky error flags.

Function
REQ-016 SHALL keep internal write/read pointers of ADDR_WIDTH+1 bits (wrap bit + address), wrapping modulo 2**(ADDR_WIDTH+1).
REQ-017 SHALL assert write_accept = write_ena & ~full; read_accept = read_ena & ~empty; flags used are the current registered values.
REQ-018 SHALL increment write pointer on write_accept, read pointer on read_accept, both in the same edge when both accepted.
REQ-019 SHALL update count: +1 write only, -1 read only, unchanged both or neither; never exceeds DEPTH nor goes below 0.
REQ-020 SHALL compute flags from next-state pointers/count so they are valid the cycle after the causing edge (1-cycle latency, no combinational path from requests to flags).
REQ-021 SHALL set empty when pointers equal in all bits; full when wrap bits differ and address bits equal.
REQ-022 SHALL set almost_full when count >= AF_LEVEL, almost_empty when count <= AE_LEVEL.
REQ-023 When full with write_ena and read_ena both high: read accepted, write rejected, overflow set.
REQ-024 When empty with read_ena and write_ena both high: write accepted, read rejected, underflow set.
REQ-025 SHALL set overflow on any edge with write_ena & full, underflow on any edge with read_ena & empty; both hold until clear_err or reset.
REQ-026 clear_err SHALL win over a same-cycle error event (flag reads 0 next cycle).
REQ-027 flush SHALL zero both pointers and count, set empty=1, almost_empty=1, full=0, almost_full=0 next cycle, ignore same-cycle write/read, and leave error flags unchanged.
REQ-028 SHALL not change pointers, count or flags on edges with no accepted access, flush or reset.

Reset
REQ-029 On rst_n low, SHALL immediately (without clock) force pointers=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0.
REQ-030 Reset deassertion mid-operation SHALL resume from the empty state on the first rising edge with rst_n high; no access during reset is recorded.

Verification (ADDR_WIDTH=2, DEPTH=4, AF_LEVEL=3, AE_LEVEL=1)
REQ-031 Fill: 4 writes from reset -> count 1,2,3,4; almost_empty drops after 2nd write, almost_full rises after 3rd, full after 4th; write_addr 0,1,2,3.
REQ-032 Wrap: 4 writes, 4 reads, 2 writes -> empty after reads; write_addr/read_addr back to 0; wrap bits differ from start; count=2, full=0.
REQ-033 Simultaneous: full + write_ena&read_ena -> count 3, full=0, overflow=1; empty + both -> count 1, empty=0, underflow=1.
REQ-034 Errors: write while full -> overflow=1, pointers unchanged; clear_err same cycle as new overflow event -> overflow=0.
REQ-035 Flush: count=3 with write_ena high + flush -> next cycle count=0, empty=1, addresses 0, error flags unchanged.
REQ-036 Async reset: assert rst_n=0 between edges with count=2 -> outputs at reset values before the next edge; first access after release writes address 0.

Source files
------------

// File: rtl/fifo_ptr_ctrl.sv
// FIFO pointer/flag controller: wrap-bit pointers, occupancy count, registered
// status flags computed from next-state values, and sticky overflow/underflow.
module fifo_ptr_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter int AF_LEVEL   = (2**ADDR_WIDTH) - 4,
  parameter int AE_LEVEL   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  write_ena,
  input  logic                  read_ena,
  input  logic                  flush,
  input  logic                  clear_err,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic [ADDR_WIDTH-1:0] read_addr,
  output logic                  write_accept,
  output logic                  read_accept,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] AF_L = AF_LEVEL[PW-1:0];
  localparam logic [PW-1:0] AE_L = AE_LEVEL[PW-1:0];

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } status_t;

  logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [PW-1:0] count_nxt;
  status_t       stat_nxt;

  assign write_accept = write_ena & ~full;
  assign read_accept  = read_ena & ~empty;
  assign write_addr   = wr_ptr[ADDR_WIDTH-1:0];
  assign read_addr    = rd_ptr[ADDR_WIDTH-1:0];

  always_comb begin
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    count_nxt  = count;
    if (flush) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
      count_nxt  = '0;
    end else begin
      if (write_accept) wr_ptr_nxt = wr_ptr + 1'b1;
      if (read_accept)  rd_ptr_nxt = rd_ptr + 1'b1;
      // Simultaneous accept leaves occupancy unchanged.
      if (write_accept && !read_accept)      count_nxt = count + 1'b1;
      else if (read_accept && !write_accept) count_nxt = count - 1'b1;
    end
  end

  always_comb begin
    stat_nxt.empty        = (wr_ptr_nxt == rd_ptr_nxt);
    stat_nxt.full         = (wr_ptr_nxt[ADDR_WIDTH] != rd_ptr_nxt[ADDR_WIDTH]) &&
                            (wr_ptr_nxt[ADDR_WIDTH-1:0] == rd_ptr_nxt[ADDR_WIDTH-1:0]);
    stat_nxt.almost_full  = (count_nxt >= AF_L);
    stat_nxt.almost_empty = (count_nxt <= AE_L);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      wr_ptr       <= wr_ptr_nxt;
      rd_ptr       <= rd_ptr_nxt;
      count        <= count_nxt;
      full         <= stat_nxt.full;
      empty        <= stat_nxt.empty;
      almost_full  <= stat_nxt.almost_full;
      almost_empty <= stat_nxt.almost_empty;
    end
  end

  // clear_err dominates any error event in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clear_err) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (write_ena && full)  overflow  <= 1'b1;
      if (read_ena  && empty) underflow <= 1'b1;
    end
  end

endmodule
